// File: rtl/xnor_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module      : xnor_stream_decoder
// Description : Unmasks XNOR-keyed link words using a matching XNOR LFSR key.
// Revision    : 1.0
// ============================================================================
module xnor_stream_decoder #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] SEED  = 16'h0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_seed,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [15:0]      word_count,
    output logic [WIDTH-1:0] key_dbg
);

    localparam logic [WIDTH-1:0] c_ALL_ONES  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] c_SEED_SAFE = (SEED == c_ALL_ONES) ? {WIDTH{1'b0}} : SEED;

    logic [WIDTH-1:0] r_key;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic [15:0]      r_word_count;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_take;
    logic [WIDTH-1:0] w_key_next;
    logic [WIDTH-1:0] w_seed_safe;

    // Fibonacci XNOR LFSR; all-ones is the lockup state and is never entered.
    assign w_key_next  = {r_key[WIDTH-2:0], ~(r_key[15] ^ r_key[14] ^ r_key[12] ^ r_key[3])};
    assign w_seed_safe = (seed_in == c_ALL_ONES) ? {WIDTH{1'b0}} : seed_in;

    assign w_in_ready = rst_n && !load_seed && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && w_in_ready;
    assign w_take     = r_out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key <= c_SEED_SAFE;
        end else if (load_seed) begin
            r_key <= w_seed_safe;
        end else if (w_accept) begin
            r_key <= w_key_next;
        end
    end

    // A simultaneous take and accept replaces the word, so valid stays high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= {WIDTH{1'b0}};
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= ~(in_data ^ r_key);
        end else if (w_take) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_count <= 16'h0000;
        end else if (w_take) begin
            r_word_count <= r_word_count + 16'h0001;
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign word_count = r_word_count;
    assign key_dbg    = r_key;

endmodule
`default_nettype wire

// File: tb/tb_xnor_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_xnor_stream_decoder
// Description : Self-checking bench with a reference transmitter and scoreboard.
// Revision    : 1.0
// ============================================================================
module tb_xnor_stream_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_seed;
    logic [15:0] seed_in;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [15:0] word_count;
    logic [15:0] key_dbg;

    xnor_stream_decoder #(.WIDTH(16), .SEED(16'h0000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_seed  (load_seed),
        .seed_in    (seed_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .word_count (word_count),
        .key_dbg    (key_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] din;
        logic [15:0] exp_data;
        logic [15:0] exp_key;
    } vec_t;

    int          n_total = 0;
    int          n_pass  = 0;
    int          bad_key = 0;
    logic [15:0] sb_q[$];
    logic [15:0] m_key;
    logic [15:0] exp_count;
    logic [15:0] cur_payload;

    function automatic logic [15:0] m_lfsr(input logic [15:0] k);
        return {k[14:0], ~(k[15] ^ k[14] ^ k[12] ^ k[3])};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    // Reference transmitter: mask the payload with the model key.
    task automatic drive_word(input logic [15:0] payload);
        cur_payload = payload;
        in_data     = ~(payload ^ m_key);
        in_valid    = 1'b1;
    endtask

    // One clock: observe handshakes just before the edge, then step past it.
    task automatic tick(output bit acc);
        logic [15:0] exp_d;
        acc = 1'b0;
        @(negedge clk);
        if (key_dbg == 16'hFFFF) bad_key++;
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_take_with_empty_queue", 32'd1, 32'd0);
            end else begin
                exp_d = sb_q.pop_front();
                check("sb_data", {16'h0, out_data}, {16'h0, exp_d});
            end
            exp_count = exp_count + 16'h1;
        end
        if (in_valid && in_ready) begin
            sb_q.push_back(cur_payload);
            m_key = m_lfsr(m_key);
            acc   = 1'b1;
        end
        if (load_seed) m_key = (seed_in == 16'hFFFF) ? 16'h0000 : seed_in;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0;
        load_seed = 1'b0;
        seed_in   = 16'h0;
        out_ready = 1'b0;
        sb_q.delete();
        m_key     = 16'h0000;
        exp_count = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t vecs[4];
        bit   acc;
        int   cyc;
        int   n;

        vecs[0] = '{din: 16'h7FFE, exp_data: 16'h8001, exp_key: 16'h0001};
        vecs[1] = '{din: 16'hEDCA, exp_data: 16'h1234, exp_key: 16'h0003};
        vecs[2] = '{din: 16'h0000, exp_data: 16'hFFFC, exp_key: 16'h0007};
        vecs[3] = '{din: 16'hFFFF, exp_data: 16'h0007, exp_key: 16'h000F};

        // Reset state, sampled while rst_n is low.
        rst_n = 1'b0; in_valid = 1'b1; in_data = 16'h1234;
        load_seed = 1'b0; seed_in = 16'h0; out_ready = 1'b1;
        m_key = 16'h0; exp_count = 16'h0; cur_payload = 16'h0;
        #12;
        check("rst_out_valid", {31'h0, out_valid}, 32'd0);
        check("rst_out_data", {16'h0, out_data}, 32'h0);
        check("rst_word_count", {16'h0, word_count}, 32'h0);
        check("rst_key", {16'h0, key_dbg}, 32'h0);
        check("rst_in_ready", {31'h0, in_ready}, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Known vectors at full throughput.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = vecs[i].din;
            @(posedge clk);
            #1;
            check("vec_out_data", {16'h0, out_data}, {16'h0, vecs[i].exp_data});
            check("vec_key", {16'h0, key_dbg}, {16'h0, vecs[i].exp_key});
            check("vec_out_valid", {31'h0, out_valid}, 32'd1);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("vec_word_count", {16'h0, word_count}, 32'd4);
        check("vec_idle_valid", {31'h0, out_valid}, 32'd0);

        // Backpressure: held word must stay put, then stream one per cycle.
        apply_reset();
        drive_word(16'h1111);
        tick(acc);
        check("bp_first_accept", {31'h0, acc}, 32'd1);
        drive_word(16'h2222);
        for (int i = 0; i < 5; i++) begin
            tick(acc);
            check("bp_no_accept", {31'h0, acc}, 32'd0);
            check("bp_in_ready", {31'h0, in_ready}, 32'd0);
            check("bp_hold_data", {16'h0, out_data}, {16'h0, sb_q[0]});
            check("bp_hold_valid", {31'h0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        n = 0; cyc = 0;
        while (n < 8 && cyc < 50) begin
            tick(acc);
            if (acc) begin
                n++;
                drive_word(16'($urandom));
            end
            cyc++;
        end
        check("bp_throughput_cycles", cyc, 8);
        in_valid = 1'b0;
        cyc = 0;
        while (sb_q.size() != 0 && cyc < 20) begin tick(acc); cyc++; end
        check("bp_drain", sb_q.size(), 0);
        check("bp_word_count", {16'h0, word_count}, 32'd9);

        // Seed loading: illegal seed substitution, then reload with a word held.
        load_seed = 1'b1; seed_in = 16'hFFFF;
        tick(acc);
        load_seed = 1'b0;
        check("seed_ffff_key", {16'h0, key_dbg}, 32'h0000);
        out_ready = 1'b0;
        drive_word(16'hC0DE);
        tick(acc);
        load_seed = 1'b1; seed_in = 16'h00FF; out_ready = 1'b1;
        #1;
        check("seed_in_ready", {31'h0, in_ready}, 32'd0);
        tick(acc);
        check("seed_no_accept", {31'h0, acc}, 32'd0);
        load_seed = 1'b0;
        check("seed_00ff_key", {16'h0, key_dbg}, 32'h00FF);
        drive_word(16'h5A5A);
        tick(acc);
        check("seed_next_accept", {31'h0, acc}, 32'd1);
        check("seed_next_key", {16'h0, key_dbg}, 32'h01FE);
        check("seed_next_data", {16'h0, out_data}, 32'h5A5A);
        in_valid = 1'b0;
        tick(acc);
        check("seed_drain", sb_q.size(), 0);

        // Asynchronous reset between edges with a word held.
        apply_reset();
        drive_word(16'hABCD);
        tick(acc);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", {31'h0, out_valid}, 32'd0);
        check("arst_key", {16'h0, key_dbg}, 32'h0000);
        check("arst_in_ready", {31'h0, in_ready}, 32'd0);
        sb_q.delete(); m_key = 16'h0; exp_count = 16'h0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("arst_post_valid", {31'h0, out_valid}, 32'd0);

        // Random loopback through the reference transmitter.
        out_ready = 1'b0;
        cur_payload = 16'($urandom);
        n = 0; cyc = 0;
        while (n < 1000 && cyc < 20000) begin
            if ($urandom_range(9) < 7) drive_word(cur_payload);
            else in_valid = 1'b0;
            out_ready = ($urandom_range(9) < 7);
            tick(acc);
            if (acc) begin
                n++;
                cur_payload = 16'($urandom);
            end
            cyc++;
        end
        check("rand_sent", n, 1000);
        in_valid = 1'b0; out_ready = 1'b1;
        cyc = 0;
        while (sb_q.size() != 0 && cyc < 20) begin tick(acc); cyc++; end
        check("rand_drain", sb_q.size(), 0);
        check("rand_word_count", {16'h0, word_count}, {16'h0, exp_count});
        check("rand_key", {16'h0, key_dbg}, {16'h0, m_key});
        check("rand_no_lockup", bad_key, 0);

        // Word counter wrap.
        apply_reset();
        out_ready = 1'b1;
        drive_word(16'($urandom));
        cyc = 0;
        while (exp_count != 16'hFFFF && cyc < 70000) begin
            tick(acc);
            if (acc) drive_word(16'($urandom));
            cyc++;
        end
        check("wrap_ffff", {16'h0, word_count}, 32'hFFFF);
        in_valid = 1'b0;
        tick(acc);
        check("wrap_zero", {16'h0, word_count}, 32'h0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
